// File: rtl/inst_fetcher_pkg.sv
// Shared widths, boolean constants and fetch FSM encoding for the instruction fetcher.
package inst_fetcher_pkg;
  localparam int ADDR_WIDTH = 32;
  localparam int INST_WIDTH = 32;
  localparam int IQ_SIZE    = 16;

  localparam logic TRUE  = 1'b1;
  localparam logic FALSE = 1'b0;

  typedef enum logic {
    IDLE     = 1'b0,
    WAIT_MEM = 1'b1
  } fetch_state_e;
endpackage

// File: rtl/inst_fetcher_icache.sv
// Direct-mapped instruction cache: combinational lookup, single-cycle fill.
// Instantiated by inst_fetcher only when INST_FETCHER_ICACHE_EN is defined.
module icache_dm #(
  parameter int ADDR_WIDTH = 32,
  parameter int INST_WIDTH = 32,
  parameter int LINES      = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic [ADDR_WIDTH-1:0] lookup_addr_in,
  output logic                  hit_out,
  output logic [INST_WIDTH-1:0] data_out,
  input  logic                  fill_en_in,
  input  logic [ADDR_WIDTH-1:0] fill_addr_in,
  input  logic [INST_WIDTH-1:0] fill_data_in
);
  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_WIDTH - IDX_W - 2;

  logic [LINES-1:0]      valid_q, valid_d;
  logic [TAG_W-1:0]      tag_q  [LINES];
  logic [INST_WIDTH-1:0] data_q [LINES];

  logic [IDX_W-1:0] lu_idx, fill_idx;
  logic [TAG_W-1:0] lu_tag, fill_tag;
  logic             unused_ok;

  assign lu_idx    = lookup_addr_in[IDX_W+1:2];
  assign lu_tag    = lookup_addr_in[ADDR_WIDTH-1:IDX_W+2];
  assign fill_idx  = fill_addr_in[IDX_W+1:2];
  assign fill_tag  = fill_addr_in[ADDR_WIDTH-1:IDX_W+2];
  assign unused_ok = ^{lookup_addr_in[1:0], fill_addr_in[1:0]};

  assign hit_out  = valid_q[lu_idx] && (tag_q[lu_idx] == lu_tag);
  assign data_out = data_q[lu_idx];

  always_comb begin
    valid_d = valid_q;
    if (fill_en_in) valid_d[fill_idx] = 1'b1;
  end

  // Only the valid bits need reset; tag/data are qualified by them.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) valid_q <= '0;
    else           valid_q <= valid_d;
  end

  always_ff @(posedge clk_in) begin
    if (fill_en_in) begin
      tag_q[fill_idx]  <= fill_tag;
      data_q[fill_idx] <= fill_data_in;
    end
  end
endmodule

// File: rtl/inst_fetcher.sv
// Sequential instruction fetch unit feeding the instruction queue.
// Define INST_FETCHER_ICACHE_EN to add a direct-mapped cache in front of memory.
module inst_fetcher
  import inst_fetcher_pkg::*;
#(
  parameter int                              ADDR_WIDTH   = inst_fetcher_pkg::ADDR_WIDTH,
  parameter int                              INST_WIDTH   = inst_fetcher_pkg::INST_WIDTH,
  parameter logic [ADDR_WIDTH-1:0]           RESET_PC     = '0,
  parameter int                              ICACHE_LINES = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  rdy_in,
  input  logic                  iq_full_iq_in,
  output logic [INST_WIDTH-1:0] inst_iq_out,
  output logic [ADDR_WIDTH-1:0] pc_iq_out,
  output logic                  rdy_inst_iq_out,
  output logic                  req_mem_out,
  output logic [ADDR_WIDTH-1:0] addr_mem_out,
  input  logic                  rdy_mem_in,
  input  logic [INST_WIDTH-1:0] inst_mem_in,
  input  logic                  refresh_rob_cdb_in,
  input  logic [ADDR_WIDTH-1:0] pc_rob_cdb_in
);
  fetch_state_e          state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d, addr_q, addr_d, pc_out_q, pc_out_d;
  logic [INST_WIDTH-1:0] inst_q, inst_d;
  logic                  req_q, req_d, push_q, push_d;
  logic                  hit;
  logic [INST_WIDTH-1:0] hit_data;
  logic                  unused_ok;

  assign unused_ok = ^pc_rob_cdb_in[1:0];

`ifdef INST_FETCHER_ICACHE_EN
  logic fill_en;

  // A refresh in the response cycle discards the word, so no fill either.
  assign fill_en = rdy_in && !refresh_rob_cdb_in && (state_q == WAIT_MEM) && rdy_mem_in;

  icache_dm #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .INST_WIDTH (INST_WIDTH),
    .LINES      (ICACHE_LINES)
  ) u_icache (
    .clk_in         (clk_in),
    .rst_n_in       (rst_n_in),
    .lookup_addr_in (pc_q),
    .hit_out        (hit),
    .data_out       (hit_data),
    .fill_en_in     (fill_en),
    .fill_addr_in   (pc_q),
    .fill_data_in   (inst_mem_in)
  );
`else
  assign hit      = FALSE;
  assign hit_data = '0;
`endif

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    addr_d   = addr_q;
    pc_out_d = pc_out_q;
    inst_d   = inst_q;
    req_d    = req_q;
    push_d   = push_q;
    if (rdy_in) begin
      if (refresh_rob_cdb_in) begin
        pc_d    = {pc_rob_cdb_in[ADDR_WIDTH-1:2], 2'b00};
        req_d   = FALSE;
        push_d  = FALSE;
        state_d = IDLE;
      end else begin
        push_d = FALSE;
        case (state_q)
          IDLE: begin
            if (!iq_full_iq_in) begin
              if (hit) begin
                inst_d   = hit_data;
                pc_out_d = pc_q;
                push_d   = TRUE;
                pc_d     = pc_q + ADDR_WIDTH'(4);
              end else begin
                req_d   = TRUE;
                addr_d  = pc_q;
                state_d = WAIT_MEM;
              end
            end
          end
          WAIT_MEM: begin
            if (rdy_mem_in) begin
              req_d    = FALSE;
              inst_d   = inst_mem_in;
              pc_out_d = pc_q;
              push_d   = TRUE;
              pc_d     = pc_q + ADDR_WIDTH'(4);
              state_d  = IDLE;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q  <= IDLE;
      pc_q     <= {RESET_PC[ADDR_WIDTH-1:2], 2'b00};
      addr_q   <= '0;
      pc_out_q <= '0;
      inst_q   <= '0;
      req_q    <= FALSE;
      push_q   <= FALSE;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      addr_q   <= addr_d;
      pc_out_q <= pc_out_d;
      inst_q   <= inst_d;
      req_q    <= req_d;
      push_q   <= push_d;
    end
  end

  assign inst_iq_out     = inst_q;
  assign pc_iq_out       = pc_out_q;
  assign rdy_inst_iq_out = push_q;
  assign req_mem_out     = req_q;
  assign addr_mem_out    = addr_q;
endmodule

// File: tb/tb_inst_fetcher.sv
// Directed bench for inst_fetcher: memory responder task plus push scoreboard.
module tb_inst_fetcher;
  localparam logic [31:0] K = 32'hA5A5A5A5;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n_in, rdy_in, iq_full_iq_in;
  logic [31:0] inst_iq_out, pc_iq_out, addr_mem_out, inst_mem_in, pc_rob_cdb_in;
  logic        rdy_inst_iq_out, req_mem_out, rdy_mem_in, refresh_rob_cdb_in;

  exp_t        sb[$];
  int          n_cmp = 0, n_err = 0, n_push = 0, n_exp = 0;
  logic [31:0] exp_pc;

  always #5 clk = ~clk;

  inst_fetcher #(
    .ADDR_WIDTH (32),
    .INST_WIDTH (32),
    .RESET_PC   (32'h0),
    .ICACHE_LINES (32)
  ) dut (
    .clk_in             (clk),
    .rst_n_in           (rst_n_in),
    .rdy_in             (rdy_in),
    .iq_full_iq_in      (iq_full_iq_in),
    .inst_iq_out        (inst_iq_out),
    .pc_iq_out          (pc_iq_out),
    .rdy_inst_iq_out    (rdy_inst_iq_out),
    .req_mem_out        (req_mem_out),
    .addr_mem_out       (addr_mem_out),
    .rdy_mem_in         (rdy_mem_in),
    .inst_mem_in        (inst_mem_in),
    .refresh_rob_cdb_in (refresh_rob_cdb_in),
    .pc_rob_cdb_in      (pc_rob_cdb_in)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // A push is consumed on the next non-frozen edge; sample mid-cycle.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n_in && rdy_in && rdy_inst_iq_out) begin
      n_push++;
      if (sb.size() == 0) check("push_expected", 64'(sb.size() != 0), 64'd1);
      else begin
        e = sb.pop_front();
        check("sb_inst", inst_iq_out, e.inst);
        check("sb_pc", pc_iq_out, e.pc);
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_refresh(input logic [31:0] target);
    refresh_rob_cdb_in = 1'b1;
    pc_rob_cdb_in      = target;
    step();
    refresh_rob_cdb_in = 1'b0;
    check("refresh_req_clr", req_mem_out, 1'b0);
    check("refresh_no_push", rdy_inst_iq_out, 1'b0);
  endtask

  // Memory model: answer the outstanding request with addr^K after lat cycles.
  task automatic serve(input int lat, input bit freeze, input bit set_full);
    logic [31:0] a;
    for (int i = 0; i < 40 && req_mem_out !== 1'b1; i++) step();
    check("req_seen", req_mem_out, 1'b1);
    a = addr_mem_out;
    check("req_addr", a, exp_pc);
    if (set_full) iq_full_iq_in = 1'b1;
    sb.push_back('{a ^ K, a});
    n_exp++;
    repeat (lat - 1) begin
      step();
      check("req_hold", {req_mem_out, addr_mem_out}, {1'b1, a});
    end
    rdy_mem_in  = 1'b1;
    inst_mem_in = a ^ K;
    step();
    rdy_mem_in  = 1'b0;
    inst_mem_in = '0;
    check("push_strobe", rdy_inst_iq_out, 1'b1);
    check("push_pc", pc_iq_out, a);
    check("push_req_low", req_mem_out, 1'b0);
    exp_pc = exp_pc + 32'd4;
    if (freeze) begin
      rdy_in = 1'b0;
      repeat (5) begin
        step();
        check("frz_strobe", rdy_inst_iq_out, 1'b1);
        check("frz_out", {inst_iq_out, pc_iq_out}, {a ^ K, a});
        check("frz_req", req_mem_out, 1'b0);
      end
      rdy_in = 1'b1;
      step();
      check("unfrz_strobe_clr", rdy_inst_iq_out, 1'b0);
      check("unfrz_req", {req_mem_out, addr_mem_out}, {1'b1, exp_pc});
    end
  endtask

  initial begin
    rst_n_in = 1'b0; rdy_in = 1'b1; iq_full_iq_in = 1'b0;
    rdy_mem_in = 1'b0; inst_mem_in = '0;
    refresh_rob_cdb_in = 1'b0; pc_rob_cdb_in = '0;
    step(); step();
    check("rst_req", req_mem_out, 1'b0);
    check("rst_strobe", rdy_inst_iq_out, 1'b0);
    check("rst_addr", addr_mem_out, 32'h0);
    check("rst_inst", inst_iq_out, 32'h0);
    check("rst_pc", pc_iq_out, 32'h0);
    rst_n_in = 1'b1;
    exp_pc = 32'h0;

    // Sequential fetch from reset; queue goes full while 0x8 is in flight.
    serve(3, 1'b0, 1'b0);
    serve(3, 1'b0, 1'b0);
    serve(3, 1'b0, 1'b1);
    repeat (10) begin
      step();
      check("full_no_req", req_mem_out, 1'b0);
    end
    iq_full_iq_in = 1'b0;
    step();
    check("release_req", {req_mem_out, addr_mem_out}, {1'b1, 32'hC});

    // Redirect racing a response: the word is dropped.
    step();
    rdy_mem_in = 1'b1; inst_mem_in = 32'hDEADBEEF;
    do_refresh(32'h1002);
    rdy_mem_in = 1'b0; inst_mem_in = '0;
    exp_pc = 32'h1000;
    serve(3, 1'b1, 1'b0);

    // Wrap-around of the PC.
    do_refresh(32'hFFFF_FFFE);
    exp_pc = 32'hFFFF_FFFC;
    serve(2, 1'b0, 1'b0);

`ifdef INST_FETCHER_ICACHE_EN
    do_refresh(32'h40);
    exp_pc = 32'h40;
    repeat (4) serve(2, 1'b0, 1'b0);
    do_refresh(32'h40);
    for (int i = 0; i < 4; i++) begin
      sb.push_back('{(32'h40 + 32'(4 * i)) ^ K, 32'h40 + 32'(4 * i)});
      n_exp++;
    end
    for (int i = 0; i < 4; i++) begin
      step();
      check("hit_strobe", rdy_inst_iq_out, 1'b1);
      check("hit_pc", pc_iq_out, 32'h40 + 32'(4 * i));
      check("hit_no_req", req_mem_out, 1'b0);
    end
    exp_pc = 32'h50;
`endif

    serve(2, 1'b0, 1'b1);
    repeat (3) begin
      step();
      check("final_no_req", req_mem_out, 1'b0);
    end
    check("push_count", n_push, n_exp);
    check("sb_drained", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
